// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types for the fetch front end
// Purpose: PcSel (shared with the branch unit), fetch FSM states, queue entry
// type and the target alignment helper.
package Bundle;

  localparam int FETCH_XLEN = 32;

  typedef enum logic [1:0] {
    PC_4     = 2'd0,
    PC_BRJMP = 2'd1,
    PC_JALR  = 2'd2,
    PC_EXC   = 2'd3
  } PcSel;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } FetchState;

  typedef struct packed {
    logic [FETCH_XLEN-1:0] pc;
    logic [FETCH_XLEN-1:0] inst;
  } FetchEntry;

  // Instruction addresses are word aligned; low two bits are dropped.
  function automatic logic [FETCH_XLEN-1:0] align_pc(input logic [FETCH_XLEN-1:0] addr);
    return {addr[FETCH_XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_queue.sv
// rtl/fetch_unit_queue.sv - 2-entry FIFO between fetch and decode
// Purpose: holds fetched {pc, inst} pairs; flush overrides push and pop.
// Ports: clk, reset (async, active high), push/push_entry, pop, flush,
//        head (oldest entry), count (0..2).
module fetch_queue
  import Bundle::*;
(
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  FetchEntry push_entry,
  input  logic      pop,
  input  logic      flush,
  output FetchEntry head,
  output logic [1:0] count
);

  FetchEntry mem [2];
  logic      rd_ptr;
  logic      wr_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) mem[i] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch front end
// Purpose: fetch PC register, redirect target mux, single-outstanding imem
// request FSM with stale-response drain, and the decode-side queue.
// Ports: clk, reset; ex_valid/pc_sel/br_target/jalr_target/exc_vector from the
//        branch unit; imem_req_* / imem_resp_* to instruction memory;
//        if_valid/if_ready/if_pc/if_inst to decode.
module fetch_unit
  import Bundle::*;
#(
  parameter int              XLEN     = FETCH_XLEN,
  parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            ex_valid,
  input  PcSel            pc_sel,
  input  logic [XLEN-1:0] br_target,
  input  logic [XLEN-1:0] jalr_target,
  input  logic [XLEN-1:0] exc_vector,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst
);

  FetchState       state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] req_pc;
  logic [XLEN-1:0] target;
  logic            redirect;
  logic            accept;
  logic            push;
  logic            pop;
  logic [1:0]      count;
  FetchEntry       head;
  FetchEntry       push_entry;

  assign redirect = ex_valid && (pc_sel != PC_4);

  always_comb begin
    target = pc;
    case (pc_sel)
      PC_BRJMP: target = align_pc(br_target);
      PC_JALR:  target = align_pc(jalr_target);
      PC_EXC:   target = align_pc(exc_vector);
      default:  target = pc;
    endcase
  end

  // Issue is gated on queue space so a returning response always fits.
  assign imem_req_valid = (state == REQ) && (count < 2'd2);
  assign imem_req_addr  = pc;
  assign accept         = imem_req_valid && imem_req_ready;

  // Only a response to a live request, not overtaken by a redirect, is kept.
  assign push       = (state == WAIT) && imem_resp_valid && !redirect;
  assign pop        = if_valid && if_ready;
  assign push_entry = '{pc: req_pc, inst: imem_resp_data};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= REQ;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else begin
      if (redirect)    pc <= target;
      else if (accept) pc <= pc + XLEN'(4);

      case (state)
        REQ: begin
          if (accept) begin
            req_pc <= pc;
            state  <= redirect ? DRAIN : WAIT;
          end
        end
        WAIT: begin
          // A response coinciding with a redirect is simply discarded.
          if (imem_resp_valid) state <= REQ;
          else if (redirect)   state <= DRAIN;
        end
        DRAIN: begin
          if (imem_resp_valid) state <= REQ;
        end
        default: state <= REQ;
      endcase
    end
  end

  fetch_queue u_queue (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .head       (head),
    .count      (count)
  );

  assign if_valid = (count != 2'd0);
  assign if_pc    = head.pc;
  assign if_inst  = head.inst;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;
  import Bundle::*;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ex_valid;
  PcSel        pc_sel;
  logic [31:0] br_target, jalr_target, exc_vector;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid, if_ready;
  logic [31:0] if_pc, if_inst;

  always #5 clk = ~clk;

  fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .ex_valid(ex_valid), .pc_sel(pc_sel),
    .br_target(br_target), .jalr_target(jalr_target), .exc_vector(exc_vector),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr), .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data), .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_inst(if_inst)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] deliv_log[$];
  logic [31:0] exp_pc;
  bit          pend, pend_stale;
  logic [31:0] pend_addr, pend_exp;
  int          wait_cnt;
  int          lat;
  int          delivered;

  typedef struct {
    logic        ex;
    PcSel        sel;
    logic [31:0] br, jalr, exc, addr;
  } vec_t;
  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [31:0] model_target(input PcSel s, input logic [31:0] b,
                                               input logic [31:0] j, input logic [31:0] e);
    logic [31:0] t;
    case (s)
      PC_BRJMP: t = b;
      PC_JALR:  t = j;
      default:  t = e;
    endcase
    return t & 32'hFFFF_FFFC;
  endfunction

  // One clock: score outputs before the edge, then advance the memory model.
  task automatic tick();
    bit          redir, acc, resp;
    logic [31:0] acc_addr, pc_before;
    redir = ex_valid && (pc_sel != PC_4);
    if (imem_req_valid) check("req_addr", imem_req_addr, exp_pc);
    if (if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        fail_now("unexpected_delivery");
      end else begin
        check("if_pc", if_pc, exp_q[0].pc);
        check("if_inst", if_inst, exp_q[0].inst);
        void'(exp_q.pop_front());
      end
      delivered++;
      deliv_log.push_back(if_pc);
    end
    resp = imem_resp_valid;
    if (resp && !pend_stale && !redir)
      exp_q.push_back('{pc: pend_exp, inst: pend_exp ^ 32'hFFFF_FFFF});
    if (redir) exp_q.delete();
    if (pend && !resp && redir) pend_stale = 1'b1;
    acc       = imem_req_valid && imem_req_ready;
    acc_addr  = imem_req_addr;
    pc_before = exp_pc;
    if (redir)    exp_pc = model_target(pc_sel, br_target, jalr_target, exc_vector);
    else if (acc) exp_pc = exp_pc + 32'd4;
    @(posedge clk);
    #1;
    if (resp) pend = 1'b0;
    if (acc) begin
      pend       = 1'b1;
      pend_stale = redir;
      pend_addr  = acc_addr;
      pend_exp   = pc_before;
      wait_cnt   = lat;
    end
    if (pend && wait_cnt > 0) wait_cnt--;
    imem_resp_valid = pend && (wait_cnt == 0);
    imem_resp_data  = imem_resp_valid ? (pend_addr ^ 32'hFFFF_FFFF) : 32'h0;
    ex_valid = 1'b0;
    if (redir) check("if_valid_after_redirect", {31'b0, if_valid}, 32'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    ex_valid = 1'b0;
    pend = 1'b0;
    pend_stale = 1'b0;
    exp_q.delete();
    exp_pc = RST_PC;
    #1;
    check("reset_if_valid", {31'b0, if_valid}, 32'h0);
    check("reset_if_pc", if_pc, 32'h0);
    check("reset_if_inst", if_inst, 32'h0);
    check("reset_req_addr", imem_req_addr, RST_PC);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_req_valid", {31'b0, imem_req_valid}, 32'h1);
  endtask

  task automatic wait_live(input string name);
    for (int i = 0; i < 20; i++) begin
      if (pend && !pend_stale && !imem_resp_valid) return;
      tick();
    end
    fail_now(name);
  endtask

  task automatic wait_resp(input string name);
    for (int i = 0; i < 20; i++) begin
      if (imem_resp_valid && !pend_stale) return;
      tick();
    end
    fail_now(name);
  endtask

  task automatic expect_first(input string name, input logic [31:0] pc_exp);
    deliv_log.delete();
    for (int i = 0; i < 40 && deliv_log.size() == 0; i++) tick();
    if (deliv_log.size() == 0) fail_now(name);
    else check(name, deliv_log[0], pc_exp);
  endtask

  task automatic redirect(input PcSel s, input logic [31:0] t);
    ex_valid    = 1'b1;
    pc_sel      = s;
    br_target   = t;
    jalr_target = t;
    exc_vector  = t;
  endtask

  initial begin
    vecs[0] = '{1'b1, PC_BRJMP, 32'h0000_0100, 32'h0,         32'h0,         32'h0000_0100};
    vecs[1] = '{1'b1, PC_JALR,  32'h0,         32'h0000_0203, 32'h0,         32'h0000_0200};
    vecs[2] = '{1'b1, PC_EXC,   32'h0,         32'h0,         32'h0000_0083, 32'h0000_0080};
    vecs[3] = '{1'b1, PC_4,     32'h0000_0500, 32'h0000_0600, 32'h0000_0700, 32'h0000_0080};
    vecs[4] = '{1'b0, PC_BRJMP, 32'h0000_0500, 32'h0,         32'h0,         32'h0000_0080};
    vecs[5] = '{1'b1, PC_BRJMP, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'hFFFF_FFFC};
    vecs[6] = '{1'b1, PC_JALR,  32'h0,         32'h0000_0002, 32'h0,         32'h0000_0000};

    ex_valid = 1'b0; pc_sel = PC_4;
    br_target = '0; jalr_target = '0; exc_vector = '0;
    if_ready = 1'b1; imem_req_ready = 1'b1;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    lat = 1; delivered = 0;
    #2;
    do_reset();

    // Sequential fetch with a 1-cycle memory.
    deliv_log.delete();
    repeat (8) tick();
    if (deliv_log.size() < 3) fail_now("seq_three");
    else begin
      check("seq_pc0", deliv_log[0], 32'h8000_0000);
      check("seq_pc1", deliv_log[1], 32'h8000_0004);
      check("seq_pc2", deliv_log[2], 32'h8000_0008);
    end
    delivered = 0;
    repeat (20) tick();
    check("throughput", delivered, 32'd10);

    // Branch while a request is live in WAIT.
    lat = 3;
    wait_live("wait_live_branch");
    redirect(PC_BRJMP, 32'h100);
    tick();
    lat = 1;
    expect_first("branch_first_pc", 32'h100);

    // Target mux vectors, with the memory refusing requests.
    imem_req_ready = 1'b0;
    repeat (6) tick();
    for (int v = 0; v < 7; v++) begin
      ex_valid    = vecs[v].ex;
      pc_sel      = vecs[v].sel;
      br_target   = vecs[v].br;
      jalr_target = vecs[v].jalr;
      exc_vector  = vecs[v].exc;
      tick();
      check($sformatf("vec%0d_addr", v), imem_req_addr, vecs[v].addr);
      check($sformatf("vec%0d_valid", v), {31'b0, imem_req_valid}, 32'h1);
    end
    imem_req_ready = 1'b1;

    // Exception in the same cycle as a live response.
    lat = 1;
    wait_resp("wait_resp_exc");
    redirect(PC_EXC, 32'h80);
    tick();
    check("exc_req_valid", {31'b0, imem_req_valid}, 32'h1);
    check("exc_req_addr", imem_req_addr, 32'h80);
    expect_first("exc_first_pc", 32'h80);

    // Backpressure from decode.
    if_ready = 1'b0;
    redirect(PC_BRJMP, 32'h1000);
    tick();
    repeat (10) tick();
    check("bp_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("bp_if_valid", {31'b0, if_valid}, 32'h1);
    check("bp_if_pc", if_pc, 32'h1000);
    if_ready = 1'b1;
    deliv_log.delete();
    repeat (20) tick();
    if (deliv_log.size() < 4) fail_now("bp_resume");
    else begin
      check("bp_pc0", deliv_log[0], 32'h1000);
      check("bp_pc1", deliv_log[1], 32'h1004);
      check("bp_pc2", deliv_log[2], 32'h1008);
      check("bp_pc3", deliv_log[3], 32'h100C);
    end

    // Two redirects while a stale request drains.
    lat = 4;
    wait_live("wait_live_drain");
    redirect(PC_BRJMP, 32'h40);
    tick();
    check("drain_req_valid0", {31'b0, imem_req_valid}, 32'h0);
    redirect(PC_JALR, 32'h60);
    tick();
    check("drain_req_valid1", {31'b0, imem_req_valid}, 32'h0);
    lat = 1;
    expect_first("drain_first_pc", 32'h60);

    // Reset while a request is outstanding.
    lat = 3;
    wait_live("wait_live_reset");
    do_reset();
    lat = 1;
    expect_first("post_reset_pc", RST_PC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch front end that consumes the `pc_sel` decision from the branch unit and turns it into the next-PC sequence. It holds the architectural fetch PC, issues one instruction-memory request at a time over a valid/ready handshake, and discards responses made stale by a redirect. Fetched instructions go to decode through a 2-entry queue. It sits between the imem port and the decode stage, closing the branch-resolution loop.

## Interface
- `XLEN`, 32, address/instruction width
- `RESET_PC`, 32'h8000_0000, fetch address after reset (bits [1:0] must be 0)

- `clk`  in  1  clock
- `reset`  in  1  asynchronous, active-high reset
- `ex_valid`  in  1  `pc_sel` and targets are meaningful this cycle
- `pc_sel`  in  `Bundle::PcSel`  PC_4 / PC_BRJMP / PC_JALR / PC_EXC
- `br_target`  in  XLEN  branch/jump target
- `jalr_target`  in  XLEN  register-indirect target
- `exc_vector`  in  XLEN  exception/trap vector
- `imem_req_valid`  out  1  fetch request valid
- `imem_req_ready`  in  1  memory accepts request
- `imem_req_addr`  out  XLEN  fetch address
- `imem_resp_valid`  in  1  response valid (exactly one per accepted request, in order, no earlier than the cycle after acceptance)
- `imem_resp_data`  in  XLEN  instruction word
- `if_valid`  out  1  instruction available to decode
- `if_ready`  in  1  decode consumes
- `if_pc`  out  XLEN  PC of presented instruction
- `if_inst`  out  XLEN  presented instruction

## Operation
- Redirect = `ex_valid && pc_sel != PC_4`. Redirect has priority over every other event in the same cycle.
- Redirect target:
  - PC_BRJMP → `br_target`.
  - PC_JALR → `jalr_target`.
  - PC_EXC → `exc_vector`.
  - Bits [1:0] of the target are forced to 0.
- PC register: on redirect, `pc <= target`. Otherwise, on an accepted request (`imem_req_valid && imem_req_ready`), `pc <= pc + 4`, wrapping modulo 2^XLEN. `imem_req_addr = pc`.
- FSM states:
  - REQ:
    - `imem_req_valid = (count < 2)`.
    - Accept without redirect → WAIT.
    - Accept with redirect → DRAIN.
  - WAIT (one live request outstanding):
    - Response without redirect: push {pc_of_request, data} into the queue, → REQ.
    - Redirect without response → DRAIN.
    - Redirect with response: drop the response, → REQ.
  - DRAIN (one stale request outstanding):
    - Response: drop it, → REQ.
    - A redirect here only updates `pc`.
- The request PC is latched at acceptance for tagging the response.
- Queue (2 entries, FIFO):
  - Push on a live response; pop on `if_valid && if_ready`.
  - Simultaneous push and pop are allowed at any count.
  - A push never overflows, because issue requires `count < 2`.
  - Redirect clears all entries at the clock edge, overriding any push or pop that cycle.
- `imem_req_valid` may drop or change address without a handshake only in a redirect cycle. The memory must tolerate this.
- Reset (asynchronous):
  - `pc = RESET_PC`, state REQ, queue empty.
  - `if_valid = 0`, `if_pc = 0`, `if_inst = 0`.
  - `imem_req_valid` is 1 in the first cycle after reset.
  - Reset mid-request abandons the request; the memory is reset with the core.

## Timing
- `if_valid`, `if_pc`, `if_inst` are driven from queue registers. No combinational path from `if_ready` to `if_valid`.
- `imem_req_valid` and `imem_req_addr` depend only on registered state. No combinational path from `imem_req_ready`.
- Best-case redirect latency with a 1-cycle memory:
  - Redirect in cycle N.
  - Request to target in N+1.
  - Response in N+2.
  - `if_valid` with `if_pc = target` in N+3.
  - If a stale request is outstanding, add the cycles until its response drains.
- Steady-state throughput is 1 instruction per 2 cycles, because only one request is outstanding at a time.
- `if_valid` deasserts in the cycle after a redirect.

## Structure
- `Bundle` package: the `PcSel` enum (already shared with the branch unit), a `FetchState` enum {REQ, WAIT, DRAIN}, and a `FetchEntry` struct {pc, inst}.
- Sub-module `fetch_queue`: 2-entry FIFO of `FetchEntry` with push, pop, flush and count. Flush has priority.
- Top `fetch_unit` contains the PC register, the FSM, the request tag register and the target mux.

## Test plan
- Reset, `if_ready=1`, 1-cycle memory returning `addr ^ 32'hFFFF_FFFF` → requests to 8000_0000, 8000_0004, 8000_0008. `if_pc`/`if_inst` match in order, one instruction every 2 cycles.
- Branch redirect: `ex_valid=1`, PC_BRJMP, `br_target=32'h100` while in WAIT → the in-flight response is dropped, `if_valid=0` next cycle, and the next delivered `if_pc=32'h100`.
- PC_JALR with `jalr_target=32'h203` → `imem_req_addr=32'h200`.
- PC_EXC with `exc_vector=32'h80` in the same cycle as a response in WAIT → response dropped, state REQ, next request at 32'h80.
- Backpressure: `if_ready=0` → after 2 instructions `count=2`, `imem_req_valid=0`. Releasing `if_ready` resumes requests with no loss or duplication.
- Redirect during DRAIN to 32'h40, then to 32'h60 → one response dropped, first delivered `if_pc=32'h60`. Asserting `reset` mid-WAIT immediately gives `if_valid=0`, and `imem_req_addr` shows RESET_PC.
